// File: rtl/beamformer_sequencer.sv
// rtl/beamformer_sequencer.sv - capture/beamform/flush run sequencer for the beamformer datapath
//
// Purpose: drives one run per go request. It streams the input signal RAM into the
// band-pass filter (FEED) and captures the filter results into the filtered-sample RAM
// (FEED/DRAIN, with an idle-cycle timeout). It then walks every captured sample through
// the beamformer in four slices (BEAM), holds the beamformer enabled for a flush tail
// (FLUSH), and pulses done.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   go                           start request (honoured only in IDLE)
//   filt_valid                   filter output valid (capture write strobe)
//   data_good                    beamformer result valid (advances sumout_address)
//   signal_address, signalinen   input signal RAM read port
//   start                        filter sink-valid (read enable delayed by RAM latency)
//   readin_address               filtered-sample RAM address (write in capture, read in BEAM)
//   filter_bram_output_write_en  filtered-sample RAM write enable
//   output_read_en               filtered-sample RAM read enable
//   startbeamformer              beamformer enable
//   slice_state, sample_index    beamformer slice select and sample number
//   sumout_address               beamformer result RAM write address
//   busy, done, timeout_err      status

module beamformer_sequencer #(
    parameter int NUM_SAMPLES   = 2048,
    parameter int DRAIN_TIMEOUT = 255,
    parameter int FLUSH_CYCLES  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        filt_valid,
    input  logic        data_good,
    output logic [10:0] signal_address,
    output logic        signalinen,
    output logic        start,
    output logic [10:0] readin_address,
    output logic        filter_bram_output_write_en,
    output logic        output_read_en,
    output logic        startbeamformer,
    output logic [1:0]  slice_state,
    output logic [15:0] sample_index,
    output logic [10:0] sumout_address,
    output logic        busy,
    output logic        done,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_BEAM,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [10:0] LAST_ADDR = 11'(NUM_SAMPLES - 1);

    state_t      state;
    state_t      state_next;

    logic [10:0] feed_cnt;
    logic [10:0] wr_cnt;
    logic [10:0] beam_addr;
    logic [1:0]  slice_cnt;
    logic [15:0] idle_cnt;
    logic [15:0] flush_cnt;

    logic        capture;
    logic        write_hit;
    logic        last_write;
    logic        drain_expired;
    logic        beam_last;
    logic        flush_last;
    logic        run_start;
    logic [16:0] idle_inc;
    logic [16:0] flush_inc;

    // Phase-end conditions. The counters compare their incremented value so that a
    // counter never has to hold the terminal count itself; the 11-bit address counters
    // therefore stop at LAST_ADDR and never wrap, even with NUM_SAMPLES = 2048.
    always_comb begin
        capture       = (state == S_FEED) || (state == S_DRAIN);
        write_hit     = capture && filt_valid;
        last_write    = write_hit && (wr_cnt == LAST_ADDR);
        idle_inc      = {1'b0, idle_cnt} + 17'd1;
        flush_inc     = {1'b0, flush_cnt} + 17'd1;
        drain_expired = (state == S_DRAIN) && !filt_valid && (idle_inc >= 17'(DRAIN_TIMEOUT));
        beam_last     = (slice_cnt == 2'd3) && (beam_addr == LAST_ADDR);
        flush_last    = flush_inc >= 17'(FLUSH_CYCLES);
        run_start     = (state == S_IDLE) && go;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (go) state_next = S_FEED;
            // A completed capture wins over the end of the feed sweep.
            S_FEED: begin
                if (last_write)                state_next = S_BEAM;
                else if (feed_cnt == LAST_ADDR) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (last_write)         state_next = S_BEAM;
                else if (drain_expired) state_next = S_DONE;
            end
            S_BEAM:  if (beam_last)  state_next = S_FLUSH;
            S_FLUSH: if (flush_last) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        signalinen                  = (state == S_FEED);
        signal_address              = (state == S_FEED) ? feed_cnt : 11'd0;
        filter_bram_output_write_en = write_hit;
        readin_address              = capture ? wr_cnt : ((state == S_BEAM) ? beam_addr : 11'd0);
        output_read_en              = (state == S_BEAM);
        startbeamformer             = (state == S_BEAM) || (state == S_FLUSH);
        slice_state                 = (state == S_BEAM) ? slice_cnt : 2'd0;
        sample_index                = (state == S_BEAM) ? {5'd0, beam_addr} : 16'd0;
        busy                        = (state != S_IDLE);
        done                        = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            feed_cnt       <= '0;
            wr_cnt         <= '0;
            beam_addr      <= '0;
            slice_cnt      <= '0;
            idle_cnt       <= '0;
            flush_cnt      <= '0;
            start          <= 1'b0;
            sumout_address <= '0;
            timeout_err    <= 1'b0;
        end else begin
            state <= state_next;

            // Signal RAM has one cycle of read latency, so the filter sink-valid is the
            // read enable one cycle late.
            start <= (state == S_FEED);

            // Every counter clears whenever its phase is not continuing, so IDLE
            // always sees all counters at zero.
            feed_cnt <= ((state == S_FEED) && (state_next == S_FEED)) ? feed_cnt + 11'd1 : 11'd0;

            if ((state_next == S_FEED) || (state_next == S_DRAIN))
                wr_cnt <= write_hit ? wr_cnt + 11'd1 : wr_cnt;
            else
                wr_cnt <= 11'd0;

            idle_cnt <= ((state == S_DRAIN) && (state_next == S_DRAIN) && !filt_valid)
                        ? idle_cnt + 16'd1 : 16'd0;

            if ((state == S_BEAM) && (state_next == S_BEAM)) begin
                slice_cnt <= slice_cnt + 2'd1;
                if (slice_cnt == 2'd3)
                    beam_addr <= beam_addr + 11'd1;
            end else begin
                slice_cnt <= 2'd0;
                beam_addr <= 11'd0;
            end

            flush_cnt <= ((state == S_FLUSH) && (state_next == S_FLUSH)) ? flush_cnt + 16'd1 : 16'd0;

            // Result address survives the return to IDLE so software can read how many
            // results were written; it restarts only when a new run begins.
            if (run_start)
                sumout_address <= 11'd0;
            else if (((state == S_BEAM) || (state == S_FLUSH)) && data_good)
                sumout_address <= sumout_address + 11'd1;

            if (run_start)
                timeout_err <= 1'b0;
            else if (drain_expired)
                timeout_err <= 1'b1;
        end
    end

endmodule
